// File: rtl/pixel_pkg.sv
// Shared types and limits for the pixel stream parser.
package pixel_pkg;

  localparam int BYTE_W        = 8;
  localparam int NUM_CH_MIN    = 1;
  localparam int NUM_CH_MAX    = 4;
  localparam int DIM_BYTES_MIN = 1;
  localparam int DIM_BYTES_MAX = 3;

  typedef enum logic {
    HDR = 1'b0,
    PIX = 1'b1
  } state_e;

endpackage

// File: rtl/pixel_pos_cnt.sv
// Column/row position tracker for one frame. Counters step once per loaded
// pixel and wrap at the frame end, so every frame starts at (0,0) without a
// separate clear. Optional x/y taps exist only with PIXEL_PARSER_COORD_EN.
module pixel_pos_cnt
  import pixel_pkg::*;
#(
  parameter int DW = 2 * BYTE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  input  logic [DW-1:0] width,
  input  logic [DW-1:0] height,
  output logic          sof,
  output logic          eol,
  output logic          eof
`ifdef PIXEL_PARSER_COORD_EN
  ,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y
`endif
);

  logic [DW-1:0] col;
  logic [DW-1:0] row;

  // Flags describe the pixel about to be loaded (current counter values).
  assign eol = (col == width - DW'(1));
  assign eof = eol && (row == height - DW'(1));
  assign sof = (col == '0) && (row == '0);

`ifdef PIXEL_PARSER_COORD_EN
  assign x = col;
  assign y = row;
`endif

  // Advance raster position on each loaded pixel; comparisons replace any multiply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + DW'(1);
      end else begin
        col <= col + DW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_parser.sv
// Byte-stream pixel parser: a header of height/width (LS byte first) is
// followed by height*width pixels of NUM_CH bytes each. Pixels are emitted
// with sof/eol/eof framing flags one cycle after their last byte.
// Optional feature macro: PIXEL_PARSER_COORD_EN adds out_x/out_y.
module pixel_parser
  import pixel_pkg::*;
#(
  parameter  int NUM_CH    = 3,
  parameter  int DIM_BYTES = 2,
  localparam int DW        = BYTE_W * DIM_BYTES,
  localparam int PW        = BYTE_W * NUM_CH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [DW-1:0]     height,
  output logic [DW-1:0]     width,
  output logic              hdr_valid,
  output logic              hdr_err
`ifdef PIXEL_PARSER_COORD_EN
  ,
  output logic [DW-1:0]     out_x,
  output logic [DW-1:0]     out_y
`endif
);

  localparam int HDR_BYTES = 2 * DIM_BYTES;
  localparam int HB        = 2 * DW - BYTE_W;

  state_e          state;
  logic [2:0]      hdr_cnt;
  logic [1:0]      ch_cnt;
  logic [HB-1:0]   hdr_buf;
  logic [2*DW-1:0] hdr_next;
  logic [PW-1:0]   pix_next;
  logic            acc, hdr_last, pix_last, hdr_ok, pix_load;
  logic            p_sof, p_eol, p_eof;
`ifdef PIXEL_PARSER_COORD_EN
  logic [DW-1:0]   p_x, p_y;
`endif

  // Stall input only while a pixel is held unconsumed; independent of in_valid.
  assign in_ready = !(out_valid && !out_ready);
  assign acc      = in_valid && in_ready;

  // Header bytes shift in from the top, so the first byte ends up as LS byte.
  assign hdr_next = {in_data, hdr_buf};
  assign hdr_last = (hdr_cnt == 3'(HDR_BYTES - 1));
  assign hdr_ok   = (hdr_next[DW-1:0] != '0) && (hdr_next[2*DW-1:DW] != '0);
  assign pix_last = (ch_cnt == 2'(NUM_CH - 1));
  assign pix_load = acc && (state == PIX) && pix_last;

  // Channel bytes shift in from the bottom: first-received lands in the MS byte.
  if (NUM_CH > 1) begin : g_pix_buf
    logic [PW-BYTE_W-1:0] pix_buf;
    assign pix_next = {pix_buf, in_data};
    // Collect leading channel bytes of the current pixel.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      pix_buf <= '0;
      else if (acc && (state == PIX)) pix_buf <= pix_next[PW-BYTE_W-1:0];
    end
  end else begin : g_pix_direct
    assign pix_next = in_data;
  end

  pixel_pos_cnt #(.DW(DW)) u_pos (
    .clk    (clk),
    .reset  (reset),
    .adv    (pix_load),
    .width  (width),
    .height (height),
    .sof    (p_sof),
    .eol    (p_eol),
    .eof    (p_eof)
`ifdef PIXEL_PARSER_COORD_EN
    ,
    .x      (p_x),
    .y      (p_y)
`endif
  );

  // HDR/PIX sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HDR;
      hdr_cnt   <= '0;
      ch_cnt    <= '0;
      hdr_buf   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      height    <= '0;
      width     <= '0;
      hdr_valid <= 1'b0;
      hdr_err   <= 1'b0;
`ifdef PIXEL_PARSER_COORD_EN
      out_x     <= '0;
      out_y     <= '0;
`endif
    end else begin
      hdr_err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        HDR: if (acc) begin
          hdr_buf <= hdr_next[2*DW-1:BYTE_W];
          if (hdr_cnt == 3'd0) hdr_valid <= 1'b0;
          if (hdr_last) begin
            hdr_cnt <= '0;
            if (hdr_ok) begin
              state     <= PIX;
              hdr_valid <= 1'b1;
              height    <= hdr_next[DW-1:0];
              width     <= hdr_next[2*DW-1:DW];
            end else begin
              hdr_err   <= 1'b1;
            end
          end else begin
            hdr_cnt <= hdr_cnt + 3'd1;
          end
        end
        PIX: if (acc) begin
          if (pix_last) begin
            ch_cnt    <= '0;
            out_data  <= pix_next;
            out_valid <= 1'b1;
            out_sof   <= p_sof;
            out_eol   <= p_eol;
            out_eof   <= p_eof;
`ifdef PIXEL_PARSER_COORD_EN
            out_x     <= p_x;
            out_y     <= p_y;
`endif
            // Next byte after the frame's last pixel is already header.
            if (p_eof) state <= HDR;
          end else begin
            ch_cnt <= ch_cnt + 2'd1;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule
